layer1_mac_seq: RTL

- Address sequencer and parallel multiply-accumulate for hidden layer 1; sits directly downstream of the weight/bias memory (wbmem).
- Drives the shared row counter `ctr1` into wbmem and the pixel address into the image memory.
- Consumes the 32 registered weight words plus one pixel per cycle and accumulates all 32 neurons in parallel.
- Adds the bias row, applies ReLU with saturation, and presents 32 hidden activations to the layer-2 stage with a done pulse.

---
 rtl/layer1_mac_seq.sv | 135 +++++++++++++
 1 files changed

// File: rtl/layer1_mac_seq.sv
// Hidden layer 1 sequencer: walks wbmem rows 0..N_IN (weights, then bias),
// multiply-accumulates all neurons in parallel against the streamed pixel,
// then applies ReLU with 32-bit saturation and presents the activations.
module layer1_mac_seq #(
    parameter int N_IN   = 784,
    parameter int N_NEUR = 32,
    parameter int PIX_W  = 8,
    parameter int ACC_W  = 56
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic [31:0]            ctr1,
    input  logic [N_NEUR*32-1:0]   w_data,
    output logic [9:0]             pix_addr,
    input  logic [PIX_W-1:0]       pix_data,
    output logic                   busy,
    output logic                   done,
    output logic [N_NEUR*32-1:0]   h_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam logic [31:0] N_IN_U = 32'(N_IN);

    state_t             state_r;
    logic               pv_r;      // a row is arriving from the memories this cycle
    logic [31:0]        pidx_r;    // index of the row arriving this cycle
    logic [ACC_W-1:0]   acc_r [N_NEUR];
    logic [31:0]        ctr1_inc_s;

    assign ctr1_inc_s = ctr1 + 32'd1;

    // Signed weight times unsigned pixel, or the bare weight for the bias row.
    // The true product fits in 40 bits, so the ACC_W-bit truncation is exact.
    function automatic logic [ACC_W-1:0] mac_term(input logic [31:0]      w,
                                                  input logic [PIX_W-1:0] p,
                                                  input logic             use_pix);
        logic [ACC_W-1:0] wx;
        logic [ACC_W-1:0] px;
        wx = {{(ACC_W-32){w[31]}}, w};
        px = {{(ACC_W-PIX_W){1'b0}}, p};
        if (use_pix) begin
            mac_term = wx * px;
        end else begin
            mac_term = wx;
        end
    endfunction

    // ReLU with saturation to the largest positive Q16.16 value.
    function automatic logic [31:0] relu_sat(input logic [ACC_W-1:0] a);
        if (a[ACC_W-1]) begin
            relu_sat = 32'h0000_0000;
        end else if (|a[ACC_W-2:31]) begin
            relu_sat = 32'h7FFF_FFFF;
        end else begin
            relu_sat = a[31:0];
        end
    endfunction

    // Sequencer state, address issue, parallel accumulation and output update.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            ctr1     <= 32'd0;
            pix_addr <= 10'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
            h_data   <= '0;
            pv_r     <= 1'b0;
            pidx_r   <= 32'd0;
            for (int i = 0; i < N_NEUR; i++) begin
                acc_r[i] <= '0;
            end
        end else begin
            done <= 1'b0;
            case (state_r)
                IDLE: begin
                    pv_r <= 1'b0;
                    if (start) begin
                        for (int i = 0; i < N_NEUR; i++) begin
                            acc_r[i] <= '0;
                        end
                        ctr1     <= 32'd0;
                        pix_addr <= 10'd0;
                        busy     <= 1'b1;
                        state_r  <= RUN;
                    end
                end
                RUN: begin
                    // Issue the next row; hold on the bias row once reached.
                    if (ctr1 < N_IN_U) begin
                        ctr1     <= ctr1_inc_s;
                        pix_addr <= ctr1_inc_s[9:0];
                    end
                    pv_r   <= 1'b1;
                    pidx_r <= ctr1;
                    if (pv_r) begin
                        for (int i = 0; i < N_NEUR; i++) begin
                            acc_r[i] <= acc_r[i] + mac_term(w_data[32*i +: 32], pix_data,
                                                            pidx_r != N_IN_U);
                        end
                        if (pidx_r == N_IN_U) begin
                            pv_r    <= 1'b0;
                            state_r <= FIN;
                        end
                    end
                end
                FIN: begin
                    for (int i = 0; i < N_NEUR; i++) begin
                        h_data[32*i +: 32] <= relu_sat(acc_r[i]);
                    end
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    ctr1     <= 32'd0;
                    pix_addr <= 10'd0;
                    pv_r     <= 1'b0;
                    state_r  <= IDLE;
                end
                default: begin
                    state_r  <= IDLE;
                    busy     <= 1'b0;
                    ctr1     <= 32'd0;
                    pix_addr <= 10'd0;
                    pv_r     <= 1'b0;
                end
            endcase
        end
    end

endmodule
